// File: rtl/mv_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mv_cmd_pkg
// Brief    : Opcodes, FSM state encoding and helpers for mv_cmd_dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
package mv_cmd_pkg;

    localparam logic [7:0] c_OP_NOP     = 8'h00;
    localparam logic [7:0] c_OP_IO      = 8'h01;
    localparam logic [7:0] c_OP_SPI0    = 8'h02;
    localparam logic [7:0] c_OP_MDIO_RD = 8'h0A;
    localparam logic [7:0] c_OP_MDIO_WR = 8'h0B;
    localparam logic [7:0] c_OP_TRACE   = 8'h0C;
    localparam logic [7:0] c_OP_CODEC   = 8'h0D;

    // Base of the trace idle/ID byte; the instance TRACEID is added to it.
    localparam logic [7:0] c_TRACE_BASE = 8'h20;

    typedef enum logic [2:0] {
        S_OPC       = 3'd0,
        S_LEN       = 3'd1,
        S_PAY       = 3'd2,
        S_MDIO_WAIT = 3'd3,
        S_MDIO_BUSY = 3'd4,
        S_MDIO_HI   = 3'd5,
        S_MDIO_LO   = 3'd6
    } state_t;

    // SPI channel opcodes occupy 0x02 .. 0x02+num_spi-1.
    function automatic logic is_spi_op(input logic [7:0] op, input int num_spi);
        return (int'(op) >= int'(c_OP_SPI0)) && (int'(op) < int'(c_OP_SPI0) + num_spi);
    endfunction

    function automatic logic is_known_op(input logic [7:0] op, input int num_spi);
        return (op == c_OP_NOP) || (op == c_OP_IO) || is_spi_op(op, num_spi) ||
               (op == c_OP_MDIO_RD) || (op == c_OP_MDIO_WR) ||
               (op == c_OP_TRACE) || (op == c_OP_CODEC);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mv_frame_timer.sv
`default_nettype none
// ============================================================================
// Module   : mv_frame_timer
// Brief    : Inter-byte idle counter; flags expiry after TIMEOUT_CYCLES idle
//            cycles while enabled.
// Revision : 1.0 - initial release
// ============================================================================
module mv_frame_timer #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam logic [15:0] c_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_count;

    // Count idle enabled cycles; any clear or leaving the timed states restarts.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= 16'd0;
        end else if (i_clear || !i_enable) begin
            r_count <= 16'd0;
        end else if (r_count != c_LAST) begin
            r_count <= r_count + 16'd1;
        end
    end

    // A clear in the same cycle (a received byte) suppresses expiry.
    assign o_expire = i_enable && !i_clear && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/mv_cmd_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : mv_cmd_dispatcher
// Brief    : Parses opcode/length/payload host frames, routes payload bytes to
//            SPI, MDIO, I/O latch, codec and trace targets, and muxes response
//            bytes back onto the tx stream.
// Revision : 1.0 - initial release
// ============================================================================
module mv_cmd_dispatcher
    import mv_cmd_pkg::*;
#(
    parameter int TRACEID        = 0,
    parameter int NUM_SPI        = 4,
    parameter int IO_PULSE_LEN   = 7,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_strobe,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_req,
    input  logic               i_spi_ready,
    input  logic [7:0]         i_spi_rd_data,
    input  logic               i_spi_rd_strobe,
    output logic               o_spi_rw_req,
    output logic [NUM_SPI-1:0] o_spi_cs_n,
    output logic [7:0]         o_mdio_register,
    output logic [15:0]        o_mdio_wr_data,
    output logic               o_mdio_rd_request,
    output logic               o_mdio_wr_request,
    input  logic               i_mdio_rw_busy,
    input  logic [15:0]        i_mdio_rd_data,
    output logic [7:0]         o_io_data,
    output logic               o_io_data_pulse,
    output logic [7:0]         o_codec_config,
    output logic               o_trace_req,
    input  logic               i_tracebuf_empty,
    input  logic [7:0]         i_trace_out_data,
    output logic               o_frame_error,
    output logic [7:0]         o_err_count,
    output logic [2:0]         o_debug_state
);

    localparam logic [7:0] c_TRACE_ID_BYTE = 8'(c_TRACE_BASE + TRACEID);
    localparam logic [4:0] c_PULSE_END     = 5'(7 + IO_PULSE_LEN);

    state_t             r_state, r_state_d;
    logic [7:0]         r_opcode, r_len, r_cnt;
    logic [NUM_SPI-1:0] r_cs_n;
    logic               r_spi_pend;
    logic               r_spi_rw_req, r_mdio_rd_req, r_mdio_wr_req, r_trace_req;
    logic [7:0]         r_mdio_reg, r_codec, r_io_data, r_err_count;
    logic [15:0]        r_mdio_wd;
    logic [4:0]         r_io_cnt;
    logic               r_io_pulse, r_frame_error;

    logic       w_is_spi, w_known, w_last, w_frame_end, w_bad, w_err;
    logic       w_timer_en, w_timer_clr, w_timeout, w_io_load, w_spi_active;
    logic [7:0] w_len, w_spi_idx;

    mv_frame_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (w_timer_clr),
        .i_enable (w_timer_en),
        .o_expire (w_timeout)
    );

    // Frame decode: last-byte detection, error conditions, timer control.
    always_comb begin
        w_is_spi     = is_spi_op(r_opcode, NUM_SPI);
        w_known      = is_known_op(r_opcode, NUM_SPI);
        w_spi_idx    = r_opcode - c_OP_SPI0;
        w_len        = (r_state == S_LEN) ? i_rx_data : r_len;
        w_last       = ((r_state == S_LEN) && (i_rx_data == 8'd0)) ||
                       ((r_state == S_PAY) && (r_cnt == r_len - 8'd1));
        w_frame_end  = i_rx_strobe && w_last;
        w_bad        = !w_known ||
                       ((r_opcode == c_OP_MDIO_WR) && (w_len < 8'd3)) ||
                       ((r_opcode == c_OP_MDIO_RD) && (w_len == 8'd0));
        w_timer_en   = (r_state == S_LEN) || (r_state == S_PAY) ||
                       (r_state == S_MDIO_WAIT) || (r_state == S_MDIO_BUSY);
        w_timer_clr  = i_rx_strobe || (r_state != r_state_d);
        w_err        = (w_frame_end && w_bad) || w_timeout ||
                       (i_rx_strobe && ((r_state == S_MDIO_HI) || (r_state == S_MDIO_LO)));
        w_io_load    = i_rx_strobe && (r_state == S_PAY) && (r_opcode == c_OP_IO) &&
                       (r_cnt == 8'd0);
        w_spi_active = (r_cs_n != {NUM_SPI{1'b1}});
    end

    // Response byte multiplexer, highest priority first.
    always_comb begin
        o_tx_data = i_rx_data;
        o_tx_req  = i_rx_strobe;
        if (w_spi_active) begin
            o_tx_data = i_spi_rd_data;
            o_tx_req  = i_spi_rd_strobe;
        end else if (r_state == S_MDIO_HI) begin
            o_tx_data = i_mdio_rd_data[15:8];
            o_tx_req  = 1'b1;
        end else if (r_state == S_MDIO_LO) begin
            o_tx_data = i_mdio_rd_data[7:0];
            o_tx_req  = 1'b1;
        end else if (!i_tracebuf_empty) begin
            o_tx_data = i_trace_out_data;
            o_tx_req  = 1'b1;
        end else if ((r_opcode == c_OP_TRACE) && ((r_state == S_LEN) || (r_state == S_PAY))) begin
            o_tx_data = c_TRACE_ID_BYTE;
            o_tx_req  = i_rx_strobe;
        end
    end

    // Frame FSM with payload routing, request pulses and chip-select control.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_OPC;
            r_state_d     <= S_OPC;
            r_opcode      <= 8'd0;
            r_len         <= 8'd0;
            r_cnt         <= 8'd0;
            r_cs_n        <= {NUM_SPI{1'b1}};
            r_spi_pend    <= 1'b0;
            r_spi_rw_req  <= 1'b0;
            r_mdio_rd_req <= 1'b0;
            r_mdio_wr_req <= 1'b0;
            r_trace_req   <= 1'b0;
            r_mdio_reg    <= 8'd0;
            r_mdio_wd     <= 16'd0;
            r_codec       <= 8'd0;
        end else begin
            r_state_d     <= r_state;
            r_spi_rw_req  <= 1'b0;
            r_mdio_rd_req <= 1'b0;
            r_mdio_wr_req <= 1'b0;
            r_trace_req   <= 1'b0;
            // Hold chip selects until the engine has finished the last byte;
            // the request cycle itself is skipped since ready has not dropped yet.
            if (r_spi_pend && i_spi_ready && !r_spi_rw_req) begin
                r_cs_n     <= {NUM_SPI{1'b1}};
                r_spi_pend <= 1'b0;
            end
            case (r_state)
                S_OPC: begin
                    if (i_rx_strobe) begin
                        r_opcode <= i_rx_data;
                        r_state  <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (i_rx_strobe) begin
                        r_len <= i_rx_data;
                        r_cnt <= 8'd0;
                        if (i_rx_data == 8'd0) begin
                            if (r_opcode == c_OP_MDIO_RD) begin
                                r_state       <= S_MDIO_WAIT;
                                r_mdio_rd_req <= 1'b1;
                            end else begin
                                r_state <= S_OPC;
                            end
                        end else begin
                            r_state <= S_PAY;
                            if (w_is_spi) begin
                                r_spi_pend <= 1'b0;
                                for (int k = 0; k < NUM_SPI; k++) begin
                                    if (w_spi_idx == 8'(k)) begin
                                        r_cs_n[k] <= 1'b0;
                                    end
                                end
                            end
                        end
                    end else if (w_timeout) begin
                        r_state <= S_OPC;
                    end
                end
                S_PAY: begin
                    if (i_rx_strobe) begin
                        r_cnt <= r_cnt + 8'd1;
                        if (w_is_spi) begin
                            r_spi_rw_req <= 1'b1;
                        end
                        if (r_opcode == c_OP_TRACE) begin
                            r_trace_req <= 1'b1;
                        end
                        if ((r_opcode == c_OP_CODEC) && (r_cnt == 8'd0)) begin
                            r_codec <= i_rx_data;
                        end
                        if (((r_opcode == c_OP_MDIO_RD) || (r_opcode == c_OP_MDIO_WR)) &&
                            (r_cnt == 8'd0)) begin
                            r_mdio_reg <= i_rx_data;
                        end
                        if ((r_opcode == c_OP_MDIO_WR) && (r_cnt == 8'd1)) begin
                            r_mdio_wd[15:8] <= i_rx_data;
                        end
                        if ((r_opcode == c_OP_MDIO_WR) && (r_cnt == 8'd2)) begin
                            r_mdio_wd[7:0] <= i_rx_data;
                            r_mdio_wr_req  <= 1'b1;
                        end
                        if (w_last) begin
                            if (w_is_spi) begin
                                r_spi_pend <= 1'b1;
                            end
                            if (r_opcode == c_OP_MDIO_RD) begin
                                r_state       <= S_MDIO_WAIT;
                                r_mdio_rd_req <= 1'b1;
                            end else begin
                                r_state <= S_OPC;
                            end
                        end
                    end else if (w_timeout) begin
                        r_state <= S_OPC;
                        if (w_spi_active) begin
                            r_spi_pend <= 1'b1;
                        end
                    end
                end
                S_MDIO_WAIT: begin
                    if (i_mdio_rw_busy) begin
                        r_state <= S_MDIO_BUSY;
                    end else if (w_timeout) begin
                        r_state <= S_OPC;
                    end
                end
                S_MDIO_BUSY: begin
                    if (!i_mdio_rw_busy) begin
                        r_state <= S_MDIO_HI;
                    end else if (w_timeout) begin
                        r_state <= S_OPC;
                    end
                end
                S_MDIO_HI: r_state <= S_MDIO_LO;
                S_MDIO_LO: r_state <= S_OPC;
                default:   r_state <= S_OPC;
            endcase
        end
    end

    // I/O latch load and delayed load pulse (high 8 .. 7+IO_PULSE_LEN cycles after the strobe).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_io_data  <= 8'd0;
            r_io_cnt   <= 5'd0;
            r_io_pulse <= 1'b0;
        end else begin
            r_io_pulse <= (r_io_cnt >= 5'd7) && (r_io_cnt < c_PULSE_END);
            if (w_io_load) begin
                r_io_data <= i_rx_data;
                r_io_cnt  <= 5'd1;
            end else if (r_io_cnt != 5'd0) begin
                r_io_cnt <= (r_io_cnt == c_PULSE_END) ? 5'd0 : r_io_cnt + 5'd1;
            end
        end
    end

    // Frame error pulse and saturating error counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame_error <= 1'b0;
            r_err_count   <= 8'd0;
        end else begin
            r_frame_error <= w_err;
            if (w_err && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign o_spi_rw_req      = r_spi_rw_req;
    assign o_spi_cs_n        = r_cs_n;
    assign o_mdio_register   = r_mdio_reg;
    assign o_mdio_wr_data    = r_mdio_wd;
    assign o_mdio_rd_request = r_mdio_rd_req;
    assign o_mdio_wr_request = r_mdio_wr_req;
    assign o_io_data         = r_io_data;
    assign o_io_data_pulse   = r_io_pulse;
    assign o_codec_config    = r_codec;
    assign o_trace_req       = r_trace_req;
    assign o_frame_error     = r_frame_error;
    assign o_err_count       = r_err_count;
    assign o_debug_state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mv_cmd_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_mv_cmd_dispatcher
// Brief    : Self-checking bench for mv_cmd_dispatcher (frame vectors plus
//            SPI, MDIO, trace, timeout, saturation and reset sequences).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mv_cmd_dispatcher;

    localparam int T_OUT = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_strobe = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_req;
    logic        spi_ready = 1'b1;
    logic [7:0]  spi_rd_data = 8'h00;
    logic        spi_rd_strobe = 1'b0;
    logic        spi_rw_req;
    logic [3:0]  spi_cs_n;
    logic [7:0]  mdio_register;
    logic [15:0] mdio_wr_data;
    logic        mdio_rd_request, mdio_wr_request;
    logic        mdio_rw_busy = 1'b0;
    logic [15:0] mdio_rd_data = 16'hBEEF;
    logic [7:0]  io_data;
    logic        io_data_pulse;
    logic [7:0]  codec_config;
    logic        trace_req;
    logic        tracebuf_empty = 1'b1;
    logic [7:0]  trace_out_data = 8'h00;
    logic        frame_error;
    logic [7:0]  err_count;
    logic [2:0]  debug_state;

    mv_cmd_dispatcher #(
        .TRACEID(3), .NUM_SPI(4), .IO_PULSE_LEN(7), .TIMEOUT_CYCLES(T_OUT)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_strobe(rx_strobe),
        .o_tx_data(tx_data), .o_tx_req(tx_req), .i_spi_ready(spi_ready),
        .i_spi_rd_data(spi_rd_data), .i_spi_rd_strobe(spi_rd_strobe),
        .o_spi_rw_req(spi_rw_req), .o_spi_cs_n(spi_cs_n),
        .o_mdio_register(mdio_register), .o_mdio_wr_data(mdio_wr_data),
        .o_mdio_rd_request(mdio_rd_request), .o_mdio_wr_request(mdio_wr_request),
        .i_mdio_rw_busy(mdio_rw_busy), .i_mdio_rd_data(mdio_rd_data),
        .o_io_data(io_data), .o_io_data_pulse(io_data_pulse),
        .o_codec_config(codec_config), .o_trace_req(trace_req),
        .i_tracebuf_empty(tracebuf_empty), .i_trace_out_data(trace_out_data),
        .o_frame_error(frame_error), .o_err_count(err_count), .o_debug_state(debug_state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Cycle monitor: samples 2ns after each falling edge.
    int         cyc = 0;
    logic [7:0] txq[$];
    int         n_rd = 0, n_wr = 0, n_rw = 0, n_fe = 0, n_tr = 0;
    int         last_strobe_cyc = 0, io_rise = 0, io_width = 0;
    logic       io_prev = 1'b0;

    always begin
        @(negedge clk);
        #2;
        cyc++;
        if (tx_req === 1'b1) txq.push_back(tx_data);
        if (mdio_rd_request === 1'b1) n_rd++;
        if (mdio_wr_request === 1'b1) n_wr++;
        if (spi_rw_req === 1'b1) n_rw++;
        if (frame_error === 1'b1) n_fe++;
        if (trace_req === 1'b1) n_tr++;
        if (rx_strobe) last_strobe_cyc = cyc;
        if (io_data_pulse === 1'b1) begin
            if (!io_prev) begin
                io_rise  = cyc;
                io_width = 1;
            end else begin
                io_width++;
            end
        end
        io_prev = (io_data_pulse === 1'b1);
    end

    // SPI engine model: busy for a few cycles per request, returns ~rx byte.
    always begin
        @(negedge clk);
        #3;
        if (spi_rw_req === 1'b1) begin
            spi_ready   = 1'b0;
            spi_rd_data = ~rx_data;
            repeat (3) @(negedge clk);
            #3 spi_rd_strobe = 1'b1;
            @(negedge clk);
            #3 spi_rd_strobe = 1'b0;
            spi_ready = 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data   = b;
        rx_strobe = 1'b1;
        @(negedge clk);
        rx_strobe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Compare the captured tx stream against n bytes packed MSB-first in exp.
    task automatic chk_txq(input string nm, input logic [39:0] exp, input int n);
        logic [39:0] e;
        e = exp;
        chk({nm, " count"}, 32'(txq.size()), 32'(n));
        for (int j = 0; j < n && j < txq.size(); j++) begin
            chk($sformatf("%s byte%0d", nm, j), 32'(txq[j]), 32'(e[39-8*j -: 8]));
        end
    endtask

    task automatic wait_ready(input string nm);
        int k;
        k = 0;
        while (spi_ready !== 1'b1 && k < 30) begin
            @(negedge clk);
            #4;
            k++;
        end
        chk({nm, " spi_ready timeout"}, 32'(spi_ready === 1'b1), 32'd1);
    endtask

    typedef struct {
        logic [39:0] bytes;
        int          n;
        logic [7:0]  io, codec, mreg;
        logic [15:0] mwd;
        logic [7:0]  err;
        int          fe, wr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int fe0, wr0, rd0, rw0, tr0, k;
        logic [39:0] fb;

        vecs[0] = '{40'h0D013C0000, 3, 8'hA5, 8'h3C, 8'h00, 16'h0000, 8'd0, 0, 0};
        vecs[1] = '{40'h0B03041234, 5, 8'hA5, 8'h3C, 8'h04, 16'h1234, 8'd0, 0, 1};
        vecs[2] = '{40'h0002AABB00, 4, 8'hA5, 8'h3C, 8'h04, 16'h1234, 8'd0, 0, 0};
        vecs[3] = '{40'h7F01990000, 3, 8'hA5, 8'h3C, 8'h04, 16'h1234, 8'd1, 1, 0};
        vecs[4] = '{40'h0B02075500, 4, 8'hA5, 8'h3C, 8'h07, 16'h5534, 8'd2, 1, 0};
        vecs[5] = '{40'h0D00000000, 2, 8'hA5, 8'h3C, 8'h07, 16'h5534, 8'd2, 0, 0};
        vecs[6] = '{40'h01025F6600, 4, 8'h5F, 8'h3C, 8'h07, 16'h5534, 8'd2, 0, 0};

        #1 rst_n = 1'b0;
        idle(3);
        #4;
        chk("reset cs_n", 32'(spi_cs_n), 32'hF);
        chk("reset state", 32'(debug_state), 32'd0);
        chk("reset err_count", 32'(err_count), 32'd0);
        chk("reset pulses", 32'({tx_req, spi_rw_req, mdio_rd_request, mdio_wr_request,
                                 trace_req, io_data_pulse, frame_error}), 32'd0);
        chk("reset regs", 32'({io_data, codec_config, mdio_register}), 32'd0);
        chk("reset mdio_wr_data", 32'(mdio_wr_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // IO frame: echo, latch value and delayed pulse timing.
        txq.delete();
        send_byte(8'h01); send_byte(8'h01); send_byte(8'hA5);
        idle(20);
        #4;
        chk("io data", 32'(io_data), 32'hA5);
        chk("io pulse delay", 32'(io_rise - last_strobe_cyc), 32'd8);
        chk("io pulse width", 32'(io_width), 32'd7);
        chk_txq("io echo", 40'h0101A50000, 3);

        // Table-driven frames with cumulative expected register state.
        for (int i = 0; i < 7; i++) begin
            fe0 = n_fe;
            wr0 = n_wr;
            fb  = vecs[i].bytes;
            for (int j = 0; j < vecs[i].n; j++) send_byte(fb[39-8*j -: 8]);
            idle(3);
            #4;
            chk($sformatf("v%0d io_data", i), 32'(io_data), 32'(vecs[i].io));
            chk($sformatf("v%0d codec", i), 32'(codec_config), 32'(vecs[i].codec));
            chk($sformatf("v%0d mdio_reg", i), 32'(mdio_register), 32'(vecs[i].mreg));
            chk($sformatf("v%0d mdio_wd", i), 32'(mdio_wr_data), 32'(vecs[i].mwd));
            chk($sformatf("v%0d err_count", i), 32'(err_count), 32'(vecs[i].err));
            chk($sformatf("v%0d frame_error", i), 32'(n_fe - fe0), 32'(vecs[i].fe));
            chk($sformatf("v%0d wr_req", i), 32'(n_wr - wr0), 32'(vecs[i].wr));
            chk($sformatf("v%0d state", i), 32'(debug_state), 32'd0);
        end

        // SPI channel 1 frame.
        txq.delete();
        rw0 = n_rw;
        send_byte(8'h03); send_byte(8'h02); send_byte(8'h12);
        #4;
        chk("spi cs during payload", 32'(spi_cs_n), 32'hD);
        wait_ready("spi b0");
        send_byte(8'h34);
        #4;
        chk("spi cs held after last", 32'(spi_cs_n), 32'hD);
        wait_ready("spi b1");
        idle(3);
        #4;
        chk("spi cs released", 32'(spi_cs_n), 32'hF);
        chk("spi rw_req count", 32'(n_rw - rw0), 32'd2);
        chk_txq("spi tx", 40'h0302EDCB00, 4);

        // MDIO read with busy high for 5 cycles.
        txq.delete();
        rd0 = n_rd;
        send_byte(8'h0A); send_byte(8'h01); send_byte(8'h1F);
        idle(2);
        mdio_rw_busy = 1'b1;
        idle(5);
        mdio_rw_busy = 1'b0;
        k = 0;
        #4;
        while (debug_state !== 3'd0 && k < 15) begin
            @(negedge clk);
            #4;
            k++;
        end
        chk("mdio rd back to S_OPC", 32'(debug_state), 32'd0);
        chk("mdio rd_request count", 32'(n_rd - rd0), 32'd1);
        chk("mdio rd register", 32'(mdio_register), 32'h1F);
        chk_txq("mdio rd tx", 40'h0A011FBEEF, 5);

        // Trace frame and trace-buffer priority.
        txq.delete();
        tr0 = n_tr;
        send_byte(8'h0C); send_byte(8'h01); send_byte(8'h77);
        idle(2);
        #4;
        chk("trace req count", 32'(n_tr - tr0), 32'd1);
        chk_txq("trace tx", 40'h0C23230000, 3);
        @(negedge clk);
        tracebuf_empty = 1'b0;
        trace_out_data = 8'h9C;
        #4;
        chk("tracebuf tx", 32'({tx_req, tx_data}), 32'h19C);
        tracebuf_empty = 1'b1;
        idle(2);

        // Inter-byte timeout mid SPI frame.
        fe0 = n_fe;
        send_byte(8'h02); send_byte(8'h05); send_byte(8'h11);
        idle(T_OUT - 3);
        #4;
        chk("timeout not early", 32'(n_fe - fe0), 32'd0);
        idle(8);
        #4;
        chk("timeout frame_error", 32'(n_fe - fe0), 32'd1);
        chk("timeout err_count", 32'(err_count), 32'd3);
        chk("timeout state", 32'(debug_state), 32'd0);
        chk("timeout cs released", 32'(spi_cs_n), 32'hF);
        send_byte(8'h0D); send_byte(8'h01); send_byte(8'h5A);
        idle(2);
        #4;
        chk("codec after timeout", 32'(codec_config), 32'h5A);

        // Error counter saturation.
        fe0 = n_fe;
        for (int i = 0; i < 300; i++) begin
            send_byte(8'h7F);
            send_byte(8'h00);
        end
        idle(3);
        #4;
        chk("err_count saturates", 32'(err_count), 32'hFF);
        chk("saturation frame_error pulses", 32'(n_fe - fe0), 32'd300);

        // Reset mid-frame aborts silently.
        fe0 = n_fe;
        send_byte(8'h0B); send_byte(8'h03); send_byte(8'h04);
        @(negedge clk);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        #4;
        chk("midreset state", 32'(debug_state), 32'd0);
        chk("midreset err_count", 32'(err_count), 32'd0);
        chk("midreset mdio_reg", 32'(mdio_register), 32'd0);
        chk("midreset no frame_error", 32'(n_fe - fe0), 32'd0);
        send_byte(8'h0D); send_byte(8'h01); send_byte(8'h11);
        idle(2);
        #4;
        chk("codec after reset", 32'(codec_config), 32'h11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
